// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register and halt-drain FSM
module if_stage #(
   parameter int XLEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int HALT_WAIT = 2
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            flush,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc_plus4,
   output logic [XLEN-1:0] ifid_instr,
   output logic [6:0]      ifid_opcode,
   output logic            ifid_valid,
   output logic            halted
);
   localparam int CW = $clog2(HALT_WAIT + 1);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
   typedef enum logic [1:0] {RUN, DRAIN, STOP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d, tgt;
   logic ifid_valid_q, ifid_valid_d, bubble, load;
   assign tgt = redirect_target & ~XLEN'(3);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pc_d = pc_q;
      bubble = 1'b0;
      load = 1'b0;
      case (state_q)
         RUN: begin
            if (redirect) begin
               pc_d = tgt;
               bubble = 1'b1;
            end else if (stall) begin
               bubble = flush;
            end else begin
               pc_d = pc_q + XLEN'(4);
               bubble = flush;
               load = !flush;
               if (!flush && imem_rdata[6:0] == 7'h7F) begin
                  state_d = DRAIN;
                  cnt_d = CW'(HALT_WAIT);
               end
            end
         end
         DRAIN: begin
            if (redirect) begin
               state_d = RUN;
               pc_d = tgt;
               bubble = 1'b1;
               cnt_d = '0;
            end else if (!stall) begin
               bubble = 1'b1;
               cnt_d = cnt_q - CW'(1);
               state_d = cnt_q == CW'(1) ? STOP : DRAIN;
            end
         end
         default: bubble = !stall;
      endcase
      ifid_pc_d = bubble ? '0 : load ? pc_q : ifid_pc_q;
      ifid_instr_d = bubble ? NOP : load ? imem_rdata : ifid_instr_q;
      ifid_valid_d = bubble ? 1'b0 : load ? 1'b1 : ifid_valid_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q <= '0;
         pc_q <= RESET_PC;
         ifid_pc_q <= '0;
         ifid_instr_q <= NOP;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pc_q <= pc_d;
         ifid_pc_q <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end
   assign pc = pc_q;
   assign imem_addr = pc_q;
   assign ifid_pc = ifid_pc_q;
   assign ifid_pc_plus4 = ifid_pc_q + XLEN'(4);
   assign ifid_instr = ifid_instr_q;
   assign ifid_opcode = ifid_instr_q[6:0];
   assign ifid_valid = ifid_valid_q;
   assign halted = state_q == STOP;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall/flush, redirect, wrap and halt drain
module tb_if_stage;
   logic clk = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
   logic [31:0] imem_addr, imem_rdata = 32'h0050_0093, redirect_target = '0;
   logic [31:0] pc, ifid_pc, ifid_pc_plus4, ifid_instr;
   logic [6:0] ifid_opcode;
   logic ifid_valid, halted;
   int vectors = 0, errors = 0;

   if_stage dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush), .redirect(redirect), .redirect_target(redirect_target),
      .pc(pc), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
      .ifid_opcode(ifid_opcode), .ifid_valid(ifid_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_instr"}, ifid_instr, 32'h13);
      chk({tag, "_opc"}, {25'd0, ifid_opcode}, 32'h13);
      chk({tag, "_ifpc"}, ifid_pc, 32'h0);
      chk({tag, "_p4"}, ifid_pc_plus4, 32'h4);
      chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'h0);
      chk({tag, "_halted"}, {31'd0, halted}, 32'h0);
   endtask

   initial begin
      step(); step();
      chk_reset("rst");
      reset = 1'b0;
      step();
      chk("n1_pc", pc, 32'h4);
      chk("n1_ifpc", ifid_pc, 32'h0);
      chk("n1_valid", {31'd0, ifid_valid}, 32'h1);
      chk("n1_instr", ifid_instr, 32'h0050_0093);
      chk("n1_opc", {25'd0, ifid_opcode}, 32'h13);
      step();
      chk("n2_pc", pc, 32'h8);
      chk("n2_ifpc", ifid_pc, 32'h4);
      chk("n2_p4", ifid_pc_plus4, 32'h8);
      stall = 1'b1;
      imem_rdata = 32'h1234_5678;
      step(); step();
      chk("st_pc", pc, 32'h8);
      chk("st_ifpc", ifid_pc, 32'h4);
      chk("st_instr", ifid_instr, 32'h0050_0093);
      chk("st_valid", {31'd0, ifid_valid}, 32'h1);
      flush = 1'b1;
      step();
      chk("sf_pc", pc, 32'h8);
      chk("sf_valid", {31'd0, ifid_valid}, 32'h0);
      chk("sf_instr", ifid_instr, 32'h13);
      chk("sf_ifpc", ifid_pc, 32'h0);
      flush = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'h0000_0103;
      step();
      chk("rd_pc", pc, 32'h100);
      chk("rd_valid", {31'd0, ifid_valid}, 32'h0);
      redirect = 1'b0;
      stall = 1'b0;
      imem_rdata = 32'h0050_0093;
      step();
      chk("rd2_pc", pc, 32'h104);
      chk("rd2_ifpc", ifid_pc, 32'h100);
      flush = 1'b1;
      step();
      chk("fl_pc", pc, 32'h108);
      chk("fl_valid", {31'd0, ifid_valid}, 32'h0);
      flush = 1'b0;
      redirect = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      step();
      chk("wr0_pc", pc, 32'hFFFF_FFFC);
      redirect = 1'b0;
      step();
      chk("wr_pc", pc, 32'h0);
      chk("wr_ifpc", ifid_pc, 32'hFFFF_FFFC);
      chk("wr_p4", ifid_pc_plus4, 32'h0);
      redirect = 1'b1;
      redirect_target = 32'h10;
      step();
      redirect = 1'b0;
      imem_rdata = 32'h0000_007F;
      step();
      chk("h_pc", pc, 32'h14);
      chk("h_instr", ifid_instr, 32'h7F);
      chk("h_halted", {31'd0, halted}, 32'h0);
      imem_rdata = 32'h0050_0093;
      stall = 1'b1;
      step();
      chk("hs_pc", pc, 32'h14);
      chk("hs_instr", ifid_instr, 32'h7F);
      chk("hs_halted", {31'd0, halted}, 32'h0);
      stall = 1'b0;
      step();
      chk("hw1_pc", pc, 32'h14);
      chk("hw1_valid", {31'd0, ifid_valid}, 32'h0);
      chk("hw1_halted", {31'd0, halted}, 32'h0);
      step();
      chk("hw2_halted", {31'd0, halted}, 32'h1);
      chk("hw2_pc", pc, 32'h14);
      redirect = 1'b1;
      redirect_target = 32'h200;
      step();
      chk("hr_pc", pc, 32'h14);
      chk("hr_addr", imem_addr, 32'h14);
      chk("hr_halted", {31'd0, halted}, 32'h1);
      redirect = 1'b0;
      reset = 1'b1;
      step();
      chk_reset("hrst");
      reset = 1'b0;
      imem_rdata = 32'h0000_007F;
      step();
      chk("c_pc", pc, 32'h4);
      imem_rdata = 32'h0050_0093;
      redirect = 1'b1;
      redirect_target = 32'h40;
      step();
      chk("c_pc2", pc, 32'h40);
      chk("c_halted", {31'd0, halted}, 32'h0);
      chk("c_valid", {31'd0, ifid_valid}, 32'h0);
      redirect = 1'b0;
      step();
      chk("c_pc3", pc, 32'h44);
      chk("c_ifpc", ifid_pc, 32'h40);
      step(); step();
      chk("c_pc4", pc, 32'h4C);
      chk("c_halted2", {31'd0, halted}, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
